// File: rtl/rc4_keystream_gen.sv
// 4-bit RC4 keystream generator: nibble key load, S-box init, KSA, then PRGA with ready/valid output.
// Define RC4_DROP_EN to discard the first DROP_N keystream nibbles.
module rc4_keystream_gen #(
   parameter int KEY_LEN = 16,
   parameter int DROP_N  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_wr,
   input  logic [3:0] key_data,
   input  logic       start,
   input  logic       stop,
   input  logic       ks_ready,
   output logic       ks_valid,
   output logic [3:0] ks_data,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE, INIT, KSA_J, KSA_SW, PR_I, PR_J, PR_SW, PR_OUT
   } state_t;

   localparam logic [3:0] KP_LAST = 4'(KEY_LEN - 1);

   state_t     state;
   logic [3:0] sbox [16];
   logic [3:0] key  [16];
   logic [3:0] i;
   logic [3:0] j;
   logic [3:0] kp;
   logic [3:0] kp_next;
   logic [3:0] pr_idx;
   logic [3:0] out_nib;

   if (KEY_LEN < 1 || KEY_LEN > 16) begin : g_bad_key_len
      $error("KEY_LEN must be in 1..16");
   end
   if (DROP_N < 0) begin : g_bad_drop_n
      $error("DROP_N must be non-negative");
   end

   // Output index is computed before the swap; the lookup returns the value that sits there after it.
   function automatic logic [3:0] swapped_lookup(input logic [3:0] t, input logic [3:0] ii,
                                                 input logic [3:0] jj, input logic [3:0] si,
                                                 input logic [3:0] sj, input logic [3:0] st);
      if (t == ii) return sj;
      if (t == jj) return si;
      return st;
   endfunction

   assign kp_next = (kp == KP_LAST) ? 4'd0 : kp + 4'd1;
   assign pr_idx  = sbox[i] + sbox[j];
   assign out_nib = swapped_lookup(pr_idx, i, j, sbox[i], sbox[j], sbox[pr_idx]);

`ifdef RC4_DROP_EN
   localparam int DCW = (DROP_N < 1) ? 1 : $clog2(DROP_N + 1);
   logic [DCW-1:0] drop_cnt;
`endif

   // S-box contents are don't-care after reset or stop, so they carry no reset.
   always_ff @(posedge clk) begin
      case (state)
         INIT: sbox[i] <= i;
         KSA_SW, PR_SW: begin
            sbox[i] <= sbox[j];
            sbox[j] <= sbox[i];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         i        <= 4'd0;
         j        <= 4'd0;
         kp       <= 4'd0;
         ks_valid <= 1'b0;
         ks_data  <= 4'd0;
         busy     <= 1'b0;
         for (int k = 0; k < 16; k++) key[k] <= 4'd0;
`ifdef RC4_DROP_EN
         drop_cnt <= '0;
`endif
      end else if (stop) begin
         state    <= IDLE;
         ks_valid <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= INIT;
                  busy  <= 1'b1;
                  i     <= 4'd0;
                  j     <= 4'd0;
                  kp    <= 4'd0;
`ifdef RC4_DROP_EN
                  drop_cnt <= '0;
`endif
               end else if (key_wr) begin
                  key[kp] <= key_data;
                  kp      <= kp_next;
               end
            end
            INIT: begin
               i <= i + 4'd1;
               if (i == 4'd15) state <= KSA_J;
            end
            KSA_J: begin
               j     <= j + sbox[i] + key[kp];
               state <= KSA_SW;
            end
            KSA_SW: begin
               kp <= kp_next;
               if (i == 4'd15) begin
                  i     <= 4'd0;
                  j     <= 4'd0;
                  state <= PR_I;
               end else begin
                  i     <= i + 4'd1;
                  state <= KSA_J;
               end
            end
            PR_I: begin
               i     <= i + 4'd1;
               state <= PR_J;
            end
            PR_J: begin
               j     <= j + sbox[i];
               state <= PR_SW;
            end
            PR_SW: begin
`ifdef RC4_DROP_EN
               if (drop_cnt != DCW'(DROP_N)) begin
                  drop_cnt <= drop_cnt + 1'b1;
                  state    <= PR_I;
               end else begin
                  ks_data  <= out_nib;
                  ks_valid <= 1'b1;
                  state    <= PR_OUT;
               end
`else
               ks_data  <= out_nib;
               ks_valid <= 1'b1;
               state    <= PR_OUT;
`endif
            end
            PR_OUT: begin
               if (ks_ready) begin
                  ks_valid <= 1'b0;
                  state    <= PR_I;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_keystream_gen.sv
// Scoreboard bench for rc4_keystream_gen: a 16-nibble-key instance (a) and a 5-nibble-key instance (b).
module tb_rc4_keystream_gen;

`ifdef RC4_DROP_EN
   localparam int DROP  = 16;
   localparam int FIRST = 99;
`else
   localparam int DROP  = 0;
   localparam int FIRST = 51;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       a_key_wr, a_start, a_stop, a_ready, a_valid, a_busy;
   logic [3:0] a_key_data, a_data;
   logic       b_key_wr, b_start, b_stop, b_ready, b_valid, b_busy;
   logic [3:0] b_key_data, b_data;

   rc4_keystream_gen #(.KEY_LEN(16), .DROP_N(16)) u_a (
      .clk(clk), .reset(reset), .key_wr(a_key_wr), .key_data(a_key_data),
      .start(a_start), .stop(a_stop), .ks_ready(a_ready),
      .ks_valid(a_valid), .ks_data(a_data), .busy(a_busy));

   rc4_keystream_gen #(.KEY_LEN(5), .DROP_N(16)) u_b (
      .clk(clk), .reset(reset), .key_wr(b_key_wr), .key_data(b_key_data),
      .start(b_start), .stop(b_stop), .ks_ready(b_ready),
      .ks_valid(b_valid), .ks_data(b_data), .busy(b_busy));

   int         checks = 0;
   int         errors = 0;
   logic [3:0] qa[$];
   logic [3:0] qb[$];
   logic [3:0] mkey[16];

   function automatic void chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endfunction

   // Reference 4-bit RC4: expected nibbles go straight into the chosen queue.
   task automatic push_model(input int klen, input int n, input bit sel);
      logic [3:0] s[16];
      logic [3:0] si, sj, tmp, t;
      for (int k = 0; k < 16; k++) s[4'(k)] = 4'(k);
      sj = 4'd0;
      for (int k = 0; k < 16; k++) begin
         sj = sj + s[4'(k)] + mkey[4'(k % klen)];
         tmp = s[4'(k)]; s[4'(k)] = s[sj]; s[sj] = tmp;
      end
      si = 4'd0;
      sj = 4'd0;
      for (int it = 0; it < n + DROP; it++) begin
         si = si + 4'd1;
         sj = sj + s[si];
         tmp = s[si]; s[si] = s[sj]; s[sj] = tmp;
         t = s[si] + s[sj];
         if (it >= DROP) begin
            if (sel) qb.push_back(s[t]);
            else     qa.push_back(s[t]);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input bit sel, input logic v);
      if (sel) b_start = v; else a_start = v;
   endtask
   task automatic set_stop(input bit sel, input logic v);
      if (sel) b_stop = v; else a_stop = v;
   endtask
   task automatic set_ready(input bit sel, input logic v);
      if (sel) b_ready = v; else a_ready = v;
   endtask
   function automatic logic valid_of(input bit sel);
      return sel ? b_valid : a_valid;
   endfunction
   function automatic logic busy_of(input bit sel);
      return sel ? b_busy : a_busy;
   endfunction
   function automatic int qsize(input bit sel);
      return sel ? qb.size() : qa.size();
   endfunction

   task automatic load_key(input bit sel, input int klen);
      for (int k = 0; k < klen; k++) begin
         if (sel) begin b_key_wr = 1'b1; b_key_data = mkey[4'(k)]; end
         else     begin a_key_wr = 1'b1; a_key_data = mkey[4'(k)]; end
         tick();
      end
      a_key_wr = 1'b0;
      b_key_wr = 1'b0;
   endtask

   task automatic start_and_time(input bit sel, input bit with_keywr);
      int seen;
      seen = 0;
      set_start(sel, 1'b1);
      if (with_keywr && !sel) begin a_key_wr = 1'b1; a_key_data = 4'd9; end
      tick();
      set_start(sel, 1'b0);
      a_key_wr = 1'b0;
      for (int e = 1; e <= 300; e++) begin
         tick();
         if (valid_of(sel)) begin seen = e; break; end
      end
      chk("first_valid_edge", seen, FIRST);
   endtask

   task automatic drain_and_stop(input bit sel);
      for (int c = 0; c < 2000 && qsize(sel) != 0; c++) tick();
      chk("queue_drained", qsize(sel), 0);
      set_stop(sel, 1'b1);
      tick();
      set_stop(sel, 1'b0);
      chk("busy_after_stop", busy_of(sel), 0);
      chk("valid_after_stop", valid_of(sel), 0);
   endtask

   task automatic run_free(input bit sel, input int klen, input bit with_keywr);
      push_model(klen, 64, sel);
      set_ready(sel, 1'b1);
      start_and_time(sel, with_keywr);
      drain_and_stop(sel);
      set_ready(sel, 1'b0);
   endtask

   task automatic monitor();
      logic [3:0] e;
      forever begin
         @(negedge clk);
         if (a_valid && a_ready) begin
            if (qa.size() == 0) chk("a_queue_nonempty", qa.size(), 1);
            else begin e = qa.pop_front(); chk("a_nibble", a_data, e); end
         end
         if (b_valid && b_ready) begin
            if (qb.size() == 0) chk("b_queue_nonempty", qb.size(), 1);
            else begin e = qb.pop_front(); chk("b_nibble", b_data, e); end
         end
      end
   endtask

   task automatic stimulus();
      logic [3:0] d;
      int         got;
      reset = 1'b1;
      {a_key_wr, a_start, a_stop, a_ready, a_key_data} = '0;
      {b_key_wr, b_start, b_stop, b_ready, b_key_data} = '0;
      repeat (3) tick();
      reset = 1'b0;
      for (int c = 0; c < 100; c++) begin
         tick();
         chk("idle_outputs", int'({a_valid, a_busy, a_data}), 0);
      end

      for (int k = 0; k < 16; k++) mkey[k] = 4'(k);
      load_key(1'b0, 16);
      run_free(1'b0, 16, 1'b1);

      // Consumer stalls on the third nibble; a key write while busy must be ignored.
      push_model(16, 64, 1'b0);
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int k = 0; k < 64; k++) begin
         got = 0;
         for (int c = 0; c < 200; c++) begin
            if (a_valid) begin got = 1; break; end
            tick();
         end
         chk("stall_nibble_present", got, 1);
         if (got == 0) break;
         if (k == 2) begin
            d = a_data;
            for (int c = 0; c < 10; c++) begin
               if (c == 4) begin a_key_wr = 1'b1; a_key_data = 4'd5; end
               tick();
               a_key_wr = 1'b0;
               chk("stall_valid", a_valid, 1);
               chk("stall_data", a_data, d);
            end
         end
         a_ready = 1'b1;
         tick();
         a_ready = 1'b0;
      end
      drain_and_stop(1'b0);

      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      repeat (29) tick();
      chk("busy_before_stop", a_busy, 1);
      a_stop = 1'b1;
      tick();
      a_stop = 1'b0;
      chk("idle_after_stop", int'({a_valid, a_busy}), 0);
      repeat (3) tick();
      run_free(1'b0, 16, 1'b0);

      mkey[0] = 4'd3; mkey[1] = 4'd1; mkey[2] = 4'd4; mkey[3] = 4'd1; mkey[4] = 4'd5;
      load_key(1'b1, 5);
      run_free(1'b1, 5, 1'b0);

      // Reset while a nibble is held, then run with the cleared key.
      a_ready = 1'b0;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int c = 0; c < 200 && !a_valid; c++) tick();
      chk("held_valid", a_valid, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("reset_outputs", int'({a_valid, a_busy, a_data}), 0);
      for (int k = 0; k < 16; k++) mkey[k] = 4'd0;
      run_free(1'b0, 16, 1'b0);
   endtask

   initial begin
      fork
         monitor();
         begin
            stimulus();
            repeat (2) tick();
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      join_any
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rc4_keystream_gen.md
RC4_KEYSTREAM_GEN -- requirements
Module: rc4_keystream_gen

Interface
REQ-001 Parameter KEY_LEN, default 16, meaning number of 4-bit key nibbles used by the schedule; legal range 1..16.
REQ-002 Parameter DROP_N, default 16, meaning number of initial keystream nibbles discarded when RC4_DROP_EN is defined.
REQ-003 Port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, meaning synchronous active-high reset.
REQ-005 Port key_wr, input, 1, meaning a key nibble is present on key_data.
REQ-006 Port key_data, input, 4, meaning the key nibble value.
REQ-007 Port start, input, 1, meaning begin the schedule (S-box init, then KSA, then PRGA) from the stored key.
REQ-008 Port stop, input, 1, meaning abort the current operation and return to IDLE.
REQ-009 Port ks_ready, input, 1, meaning the consumer accepts ks_data this cycle.
REQ-010 Port ks_valid, output, 1, meaning ks_data holds a keystream nibble.
REQ-011 Port ks_data, output, 4, meaning the keystream nibble.
REQ-012 Port busy, output, 1, meaning the state is not IDLE.

Function
REQ-013 The block SHALL hold a 16x4 S-box register array, a KEY_LEN x4 key array, 4-bit indices i and j, and a key pointer kp that wraps from KEY_LEN-1 to 0.
REQ-014 In IDLE, key_wr SHALL write key_data to key[kp] and increment kp (wrapping); key_wr outside IDLE SHALL be ignored; start SHALL take priority over key_wr in the same cycle, and that key_wr SHALL be dropped.
REQ-015 start sampled in IDLE SHALL enter INIT and clear i, j, and kp; start outside IDLE SHALL be ignored.
REQ-016 INIT SHALL last 16 cycles, writing S[k]=k for k=0..15 (one entry per cycle), then enter KSA_J with i=0.
REQ-017 In KSA_J, j SHALL be updated to j+S[i]+key[kp] mod 16; in the following KSA_SW, S[i] and S[j] SHALL swap, i SHALL increment, and kp SHALL advance; the sequence repeats for i=0..15 (32 cycles total).
REQ-018 After the KSA_SW with i=15, the block SHALL clear i and j and enter PR_I.
REQ-019 The PRGA sequence SHALL be: PR_I sets i=i+1; PR_J sets j=j+S[i]; PR_SW swaps S[i] and S[j]; PR_OUT registers ks_data=S[(S[i]+S[j]) mod 16] and asserts ks_valid. All arithmetic is mod 16 with carry discarded.
REQ-020 When i equals j, PR_SW and KSA_SW SHALL leave S unchanged.
REQ-021 In PR_OUT, ks_valid and ks_data SHALL hold stable until ks_valid and ks_ready are both high; on that cycle, the next state SHALL be PR_I and ks_valid SHALL drop.
REQ-022 Throughput SHALL be at most one nibble per 4 cycles; the first ks_valid SHALL rise on the 51st rising edge after the edge that samples start, with RC4_DROP_EN undefined.
REQ-023 stop SHALL take priority over all other inputs except reset, and SHALL force IDLE on the next edge with ks_valid=0; the S-box contents are then don't-care, while the key array and kp are retained.
REQ-024 busy SHALL be 0 in IDLE and 1 in every other state.

Reset
REQ-025 On reset, the block SHALL enter IDLE with ks_valid=0, ks_data=0, busy=0, i=0, j=0, and kp=0, from any state, including mid-KSA or while ks_valid is held.
REQ-026 Reset SHALL clear all key array entries to 0.

Configuration
REQ-027 With macro RC4_DROP_EN defined, the first DROP_N PRGA iterations SHALL execute PR_I, PR_J, and PR_SW, then skip PR_OUT and return directly to PR_I without asserting ks_valid; with DROP_N=16, the first ks_valid SHALL rise on edge 99.
REQ-028 With RC4_DROP_EN undefined, no nibbles SHALL be discarded, and DROP_N and the drop counter SHALL be absent from the logic.

Verification
REQ-029 Reset, then idle: ks_valid=0, ks_data=0, busy=0 -> all remain 0 for 100 cycles with start low.
REQ-030 KEY_LEN=16, key nibbles 0..15, start, ks_ready=1 -> ks_valid first rises on edge 51, and 64 nibbles match a software 4-bit RC4 model.
REQ-031 Same key, ks_ready low for 10 cycles at the 3rd nibble -> ks_data stable and ks_valid high throughout, and the sequence is unchanged versus REQ-030.
REQ-032 KEY_LEN=5, key {3,1,4,1,5} -> key index wraps every 5 KSA steps, and output matches the model.
REQ-033 stop asserted during KSA (edge 30), then start again -> IDLE on edge 31, and the restarted output is identical to an uninterrupted run.
REQ-034 RC4_DROP_EN defined, DROP_N=16, key 0..15 -> first ks_valid on edge 99, and its ks_data equals the 17th nibble from REQ-030.
